key_debounce_repeat: RTL

Conditions one raw push-button input into clean, single-cycle press events for the rest of the design. It sits directly upstream of the random-latch stage and of any game-control logic that needs key events. It synchronises the asynchronous key line, debounces it, and emits a one-clock `key_rise` pulse on each accepted press. With auto-repeat enabled, it also emits periodic repeat pulses while the key is held.

---
 rtl/key_pkg.sv | 15 +
 rtl/debounce_filter.sv | 55 +++++
 rtl/key_debounce_repeat.sv | 95 +++++++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default timing constants for the key conditioner
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEATING
    } key_state_t;

    // Default timing constants in 50 MHz clock cycles
    localparam int KEY_DEBOUNCE_10MS    = 500000;
    localparam int KEY_REPEAT_DELAY_0S5 = 25000000;
    localparam int KEY_REPEAT_RATE_0S1  = 5000000;

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - key synchroniser and debounce counter with level-change strobes
module debounce_filter
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyN,
    output logic key_level,
    output logic level_rise,
    output logic level_fall
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   pressed_s;
    logic                   differs;
    logic                   db_done;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], keyN};
        end
    end

    assign pressed_s = ~sync_q[SYNC_STAGES-1];
    assign differs   = (pressed_s != key_level);
    assign db_done   = differs && (db_cnt == DB_TERM);

    // Strobes are combinational so the event FSM registers its pulse on the same edge as key_level
    assign level_rise = db_done && !key_level;
    assign level_fall = db_done && key_level;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            db_cnt    <= '0;
            key_level <= 1'b0;
        end else if (!differs) begin
            db_cnt <= '0;
        end else if (db_done) begin
            db_cnt    <= '0;
            key_level <= ~key_level;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/key_debounce_repeat.sv
// rtl/key_debounce_repeat.sv - debounced key press/release events with optional auto-repeat
module key_debounce_repeat
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_10MS,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_0S5,
    parameter int REPEAT_RATE     = KEY_REPEAT_RATE_0S1
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyN,
    output logic key_level,
    output logic key_rise,
    output logic key_fall
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_TERM = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_TERM  = REP_W'(REPEAT_RATE - 1);

    key_state_t       state;
    logic [REP_W-1:0] rep_cnt;
    logic             level_rise;
    logic             level_fall;

    debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .resetN    (resetN),
        .keyN      (keyN),
        .key_level (key_level),
        .level_rise(level_rise),
        .level_fall(level_fall)
    );

    // Release is tested first in HELD/REPEATING so it wins over a coincident repeat
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            rep_cnt  <= '0;
            key_rise <= 1'b0;
            key_fall <= 1'b0;
        end else begin
            key_rise <= 1'b0;
            key_fall <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_rise) begin
                        key_rise <= 1'b1;
                        rep_cnt  <= '0;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    if (level_fall) begin
                        key_fall <= 1'b1;
                        rep_cnt  <= '0;
                        state    <= IDLE;
                    end else if (rep_cnt == DELAY_TERM) begin
                        // Without repeat the count parks at its terminal value
                        if (REPEAT_EN != 0) begin
                            key_rise <= 1'b1;
                            rep_cnt  <= '0;
                            state    <= REPEATING;
                        end
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                REPEATING: begin
                    if (level_fall) begin
                        key_fall <= 1'b1;
                        rep_cnt  <= '0;
                        state    <= IDLE;
                    end else if (rep_cnt == RATE_TERM) begin
                        key_rise <= 1'b1;
                        rep_cnt  <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                end
            endcase
        end
    end

endmodule
